// File: rtl/fios_res_unload.sv
// Collects an s-limb multiplier result, applies one conditional modulus subtraction, then streams the limbs out.
// Macro FIOS_FINAL_SUB_EN enables the subtraction path; when undefined the raw result is forwarded.
module fios_res_unload #(
   parameter int s = 8
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 RES_push_i,
   input  logic [16:0]          RES_i,
   input  logic                 done_i,
   input  logic                 p_we_i,
   input  logic [$clog2(s)-1:0] p_waddr_i,
   input  logic [16:0]          p_wdata_i,
   output logic                 ready_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [16:0]          out_data_o,
   output logic                 out_last_o,
   output logic                 sub_o,
   output logic                 err_o
);

   localparam int AW = $clog2(s);
   localparam logic [AW-1:0] LAST = AW'(s - 1);

   typedef enum logic [1:0] {COLLECT, FINAL, DRAIN} state_t;

   state_t        state_reg;
   logic [AW-1:0] cnt_reg;
   logic [AW-1:0] idx_reg;
   logic          sel_reg;
   logic          err_reg;
   logic          ready_reg;
   logic          out_valid_reg;
   logic          out_last_reg;
   logic          sub_reg;
   logic [16:0]   out_data_reg;

   logic [16:0]   r_mem_reg [s];

   logic          push_ok;
   logic          cnt_last;
   logic          done_err;
   logic [AW-1:0] cnt_next;
   logic [AW-1:0] idx_inc;
   logic [AW-1:0] rd_idx;
   logic [16:0]   rd_data;
   logic          final_sel;

   assign push_ok  = RES_push_i && (state_reg == COLLECT);
   assign cnt_last = (cnt_reg == LAST);
   assign cnt_next = cnt_last ? '0 : cnt_reg + 1'b1;
   assign idx_inc  = idx_reg + 1'b1;
   // A done pulse is only legal at a result boundary: idle, or on the final limb push.
   assign done_err = done_i && (state_reg == COLLECT) && (cnt_reg != '0) && !(push_ok && cnt_last);

`ifdef FIOS_FINAL_SUB_EN
   logic [16:0] p_mem_reg [s];
   logic [16:0] d_mem_reg [s];
   logic        bin_reg;
   logic [16:0] p_rd;
   logic [17:0] diff;

   assign p_rd      = p_mem_reg[cnt_reg];
   assign diff      = {1'b0, RES_i} - {1'b0, p_rd} - {17'd0, bin_reg};
   assign final_sel = ~bin_reg;

   for (genvar gi = 0; gi < s; gi++) begin : g_limb
      always_ff @(posedge clock_i) begin
         if (p_we_i && (p_waddr_i == AW'(gi)))
            p_mem_reg[gi] <= p_wdata_i;
         if (push_ok && (cnt_reg == AW'(gi))) begin
            r_mem_reg[gi] <= RES_i;
            d_mem_reg[gi] <= diff[16:0];
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i)
         bin_reg <= 1'b0;
      else if (state_reg == DRAIN && out_ready_i && idx_reg == LAST)
         bin_reg <= 1'b0;
      else if (push_ok)
         bin_reg <= diff[17];
   end

   always_comb begin
      rd_idx  = '0;
      rd_data = '0;
      if (state_reg == DRAIN)
         rd_idx = (idx_reg == LAST) ? '0 : idx_inc;
      if ((state_reg == FINAL) ? final_sel : sel_reg)
         rd_data = d_mem_reg[rd_idx];
      else
         rd_data = r_mem_reg[rd_idx];
   end
`else
   // Without the subtraction path the modulus port has nothing to feed.
   logic unused_modulus;
   assign unused_modulus = ^{p_we_i, p_waddr_i, p_wdata_i};
   assign final_sel      = 1'b0;

   for (genvar gi = 0; gi < s; gi++) begin : g_limb
      always_ff @(posedge clock_i) begin
         if (push_ok && (cnt_reg == AW'(gi)))
            r_mem_reg[gi] <= RES_i;
      end
   end

   always_comb begin
      rd_idx = '0;
      if (state_reg == DRAIN)
         rd_idx = (idx_reg == LAST) ? '0 : idx_inc;
      rd_data = r_mem_reg[rd_idx];
   end
`endif

   // Output limb is read one step ahead so out_data_o comes straight from a register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_reg     <= COLLECT;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         sel_reg       <= 1'b0;
         err_reg       <= 1'b0;
         ready_reg     <= 1'b1;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         sub_reg       <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         if ((RES_push_i && state_reg != COLLECT) || done_err)
            err_reg <= 1'b1;
         case (state_reg)
            COLLECT: begin
               if (push_ok) begin
                  cnt_reg <= cnt_next;
                  if (cnt_last) begin
                     state_reg <= FINAL;
                     ready_reg <= 1'b0;
                  end
               end
            end
            FINAL: begin
               sel_reg       <= final_sel;
               sub_reg       <= final_sel;
               idx_reg       <= '0;
               out_data_reg  <= rd_data;
               out_valid_reg <= 1'b1;
               out_last_reg  <= 1'b0;
               state_reg     <= DRAIN;
            end
            DRAIN: begin
               if (out_ready_i) begin
                  if (idx_reg == LAST) begin
                     state_reg     <= COLLECT;
                     idx_reg       <= '0;
                     cnt_reg       <= '0;
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     sub_reg       <= 1'b0;
                     ready_reg     <= 1'b1;
                  end else begin
                     idx_reg      <= idx_inc;
                     out_data_reg <= rd_data;
                     out_last_reg <= (idx_inc == LAST);
                  end
               end
            end
            default: state_reg <= COLLECT;
         endcase
      end
   end

   assign ready_o     = ready_reg;
   assign out_valid_o = out_valid_reg;
   assign out_data_o  = out_data_reg;
   assign out_last_o  = out_last_reg;
   assign sub_o       = sub_reg;
   assign err_o       = err_reg;

endmodule

// File: tb/tb_fios_res_unload.sv
// Directed bench for fios_res_unload with s=2 and modulus P = {0x00001, 0x00005}.
module tb_fios_res_unload;

   localparam int S = 2;
`ifdef FIOS_FINAL_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        RES_push_i = 1'b0;
   logic [16:0] RES_i = '0;
   logic        done_i = 1'b0;
   logic        p_we_i = 1'b0;
   logic        p_waddr_i = 1'b0;
   logic [16:0] p_wdata_i = '0;
   logic        ready_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [16:0] out_data_o;
   logic        out_last_o;
   logic        sub_o;
   logic        err_o;

   int n_cmp = 0;
   int n_err = 0;

   fios_res_unload #(.s(S)) dut (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .RES_push_i (RES_push_i),
      .RES_i      (RES_i),
      .done_i     (done_i),
      .p_we_i     (p_we_i),
      .p_waddr_i  (p_waddr_i),
      .p_wdata_i  (p_wdata_i),
      .ready_o    (ready_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o (out_data_o),
      .out_last_o (out_last_o),
      .sub_o      (sub_o),
      .err_o      (err_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check_val("rst_ready", 32'(ready_o), 32'd1);
      check_val("rst_valid", 32'(out_valid_o), 32'd0);
      check_val("rst_last", 32'(out_last_o), 32'd0);
      check_val("rst_sub", 32'(sub_o), 32'd0);
      check_val("rst_err", 32'(err_o), 32'd0);
   endtask

   task automatic write_p(input logic idx, input logic [16:0] data);
      p_we_i = 1'b1; p_waddr_i = idx; p_wdata_i = data;
      tick();
      p_we_i = 1'b0;
   endtask

   task automatic push(input logic [16:0] data, input logic with_done);
      RES_push_i = 1'b1; RES_i = data; done_i = with_done;
      tick();
      RES_push_i = 1'b0; done_i = 1'b0;
      $display("push 0x%05h done=%0d", data, with_done);
   endtask

   // Expects FINAL after the last push, then DRAIN; stalls limb 0 and may inject a push there.
   task automatic drain(input string name, input logic [16:0] e0, input logic [16:0] e1,
                        input logic esub, input int stall, input logic inject);
      logic [16:0] exp_d [2];
      exp_d[0] = e0; exp_d[1] = e1;
      check_val({name, "_final_valid"}, 32'(out_valid_o), 32'd0);
      check_val({name, "_final_ready"}, 32'(ready_o), 32'd0);
      tick();
      for (int i = 0; i < S; i++) begin
         for (int k = 0; k < ((i == 0) ? stall : 0); k++) begin
            RES_push_i = inject && (k == 0);
            RES_i = 17'h1ABCD;
            check_val({name, "_stall_data"}, 32'(out_data_o), 32'(exp_d[i]));
            check_val({name, "_stall_ready"}, 32'(ready_o), 32'd0);
            tick();
            RES_push_i = 1'b0;
         end
         check_val({name, "_valid"}, 32'(out_valid_o), 32'd1);
         check_val({name, "_data"}, 32'(out_data_o), 32'(exp_d[i]));
         check_val({name, "_last"}, 32'(out_last_o), 32'(i == S - 1));
         check_val({name, "_sub"}, 32'(sub_o), 32'(esub));
         $display("%s limb %0d data 0x%05h last=%0d sub=%0d", name, i, out_data_o, out_last_o, sub_o);
         out_ready_i = 1'b1;
         tick();
         out_ready_i = 1'b0;
      end
      check_val({name, "_end_valid"}, 32'(out_valid_o), 32'd0);
      check_val({name, "_end_ready"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      do_reset();
      write_p(1'b0, 17'h00005);
      write_p(1'b1, 17'h00001);
      tick();

      // done with cnt == 0 is harmless
      done_i = 1'b1; tick(); done_i = 1'b0;
      check_val("idle_done_err", 32'(err_o), 32'd0);

      push(17'h00007, 1'b0); push(17'h00001, 1'b0);
      drain("r7_1", SUB_EN ? 17'h00002 : 17'h00007, SUB_EN ? 17'h00000 : 17'h00001, SUB_EN, 0, 1'b0);

      push(17'h00003, 1'b0); push(17'h00001, 1'b0);
      drain("r3_1", 17'h00003, 17'h00001, 1'b0, 0, 1'b0);

      push(17'h00005, 1'b0); push(17'h00001, 1'b0);
      drain("r5_1_stall", SUB_EN ? 17'h00000 : 17'h00005, SUB_EN ? 17'h00000 : 17'h00001, SUB_EN, 3, 1'b0);
      check_val("no_err_yet", 32'(err_o), 32'd0);

      push(17'h00007, 1'b0); push(17'h00001, 1'b0);
      drain("drain_push", SUB_EN ? 17'h00002 : 17'h00007, SUB_EN ? 17'h00000 : 17'h00001, SUB_EN, 2, 1'b1);
      check_val("drain_push_err", 32'(err_o), 32'd1);

      do_reset();
      push(17'h00007, 1'b0);
      done_i = 1'b1; tick(); done_i = 1'b0;
      check_val("early_done_err", 32'(err_o), 32'd1);
      check_val("early_done_ready", 32'(ready_o), 32'd1);
      push(17'h00001, 1'b0);
      drain("after_done", SUB_EN ? 17'h00002 : 17'h00007, SUB_EN ? 17'h00000 : 17'h00001, SUB_EN, 0, 1'b0);

      do_reset();
      push(17'h00005, 1'b0); push(17'h00001, 1'b1);
      check_val("last_done_err", 32'(err_o), 32'd0);
      drain("with_done", SUB_EN ? 17'h00000 : 17'h00005, SUB_EN ? 17'h00000 : 17'h00001, SUB_EN, 0, 1'b0);

      push(17'h00003, 1'b0);
      do_reset();
      push(17'h00007, 1'b0); push(17'h00001, 1'b0);
      drain("post_rst", SUB_EN ? 17'h00002 : 17'h00007, SUB_EN ? 17'h00000 : 17'h00001, SUB_EN, 0, 1'b0);
      check_val("final_err", 32'(err_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
